r5fp_div_seq: RTL

R5FP_DIV_SEQ -- requirements
Module: R5FP_div_seq

---
 rtl/r5fp_div_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/r5fp_div_seq.sv
// Sequential restoring floating-point divider, expanded operand format, one quotient bit per cycle.
// Optional macro R5FP_DIV_EARLY_OUT_EN: special-case operands go straight from IDLE to DONE.
module r5fp_div_seq #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned SIG_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+SIG_W:0] a,
  input  logic [EXP_W+SIG_W:0] b,
  input  logic [2:0]           rnd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+SIG_W:0] z,
  output logic [4:0]           status
);
  localparam int unsigned W   = EXP_W + SIG_W + 1;
  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned NIT = SIG_W + 3;
  localparam int unsigned CW  = $clog2(NIT + 1);

  localparam logic [EXP_W-1:0]     ExpOnes   = '1;
  localparam logic [EXP_W-1:0]     ExpMaxFin = ExpOnes - 1'b1;
  localparam logic signed [EW-1:0] Bias      = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] ExpMax    = {2'b00, ExpOnes};
  localparam logic signed [EW-1:0] ExpZero   = '0;

  typedef enum logic [1:0] {StIdle, StCalc, StRound, StDone} state_e;

  state_e state_q, state_d;

  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [SIG_W-1:0]     fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn, accept;
  logic                 spec_hit;
  logic [W-1:0]         spec_z;
  logic [4:0]           spec_st;
  logic                 a_lt;
  logic [SIG_W+1:0]     rem_init, rem_sub;
  logic signed [EW-1:0] exp_init;

  logic [CW-1:0]        cnt_q;
  logic [SIG_W+1:0]     rem_q, div_q;
  logic [NIT-2:0]       quo_q;  // {fraction, guard, round}; the integer bit shifts out
  logic signed [EW-1:0] exp_q;
  logic                 sign_q, special_q;
  logic [2:0]           rnd_q;
  logic [W-1:0]         spec_z_q, z_q;
  logic [4:0]           spec_st_q, status_q;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == ExpOnes) && (fa == '0);
  assign b_inf  = (eb == ExpOnes) && (fb == '0);
  assign a_nan  = (ea == ExpOnes) && (fa != '0);
  assign b_nan  = (eb == ExpOnes) && (fb != '0);
  assign sgn    = sa ^ sb;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign z         = z_q;
  assign status    = status_q;

  always_comb begin
    spec_hit = 1'b1;
    spec_z   = '0;
    spec_st  = '0;
    if (a_nan) begin
      spec_z     = a;
      spec_st[4] = ~fa[SIG_W-1];
    end else if (b_nan) begin
      spec_z     = b;
      spec_st[4] = ~fb[SIG_W-1];
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_z     = {1'b0, ExpOnes, SIG_W'(1)};
      spec_st[4] = 1'b1;
    end else if (a_inf) begin
      spec_z = {sgn, ExpOnes, {SIG_W{1'b0}}};
    end else if (b_zero) begin
      spec_z     = {sgn, ExpOnes, {SIG_W{1'b0}}};
      spec_st[3] = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_z = {sgn, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Both significands carry a hidden 1, so comparing fractions orders them.
  assign a_lt     = (fa < fb);
  assign rem_init = a_lt ? {1'b1, fa, 1'b0} : {2'b01, fa};
  assign exp_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + Bias
                    - $signed({{(EW-1){1'b0}}, a_lt});

  assign rem_sub = (rem_q >= div_q) ? (rem_q - div_q) : rem_q;

  logic                 g, r, st, inc, to_inf, carry;
  logic [SIG_W:0]       frac_sum;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         round_z;
  logic [4:0]           round_st;

  always_comb begin
    g      = quo_q[1];
    r      = quo_q[0];
    st     = |rem_q;
    inc    = 1'b0;
    to_inf = 1'b1;
    case (rnd_q)
      3'd1: to_inf = 1'b0;
      3'd2: begin
        inc    = sign_q & (g | r | st);
        to_inf = sign_q;
      end
      3'd3: begin
        inc    = ~sign_q & (g | r | st);
        to_inf = ~sign_q;
      end
      3'd4:    inc = g;
      default: inc = g & (r | st | quo_q[2]);
    endcase
    frac_sum = {1'b0, quo_q[NIT-2:2]} + {{SIG_W{1'b0}}, inc};
    carry    = frac_sum[SIG_W];
    exp_r    = exp_q + $signed({{(EW-1){1'b0}}, carry});
    round_st = {4'b0000, g | r | st};
    round_z  = {sign_q, exp_r[EXP_W-1:0], frac_sum[SIG_W-1:0]};
    if (exp_r >= ExpMax) begin
      round_st = 5'b00101;
      round_z  = to_inf ? {sign_q, ExpOnes, {SIG_W{1'b0}}} : {sign_q, ExpMaxFin, {SIG_W{1'b1}}};
    end else if (exp_r <= ExpZero) begin
      round_st = 5'b00011;
      round_z  = {sign_q, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
`ifdef R5FP_DIV_EARLY_OUT_EN
          state_d = spec_hit ? StDone : StCalc;
`else
          state_d = StCalc;
`endif
        end
      end
      StCalc:  if (cnt_q == CW'(NIT - 1)) state_d = StRound;
      StRound: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      rnd_q     <= '0;
      special_q <= 1'b0;
      spec_z_q  <= '0;
      spec_st_q <= '0;
      z_q       <= '0;
      status_q  <= '0;
    end else begin
      if (accept) begin
        cnt_q     <= '0;
        rem_q     <= rem_init;
        div_q     <= {2'b01, fb};
        quo_q     <= '0;
        exp_q     <= exp_init;
        sign_q    <= sgn;
        rnd_q     <= rnd;
        special_q <= spec_hit;
        spec_z_q  <= spec_z;
        spec_st_q <= spec_st;
      end else if (state_q == StCalc) begin
        cnt_q <= cnt_q + CW'(1);
        rem_q <= rem_sub << 1;
        quo_q <= {quo_q[NIT-3:0], rem_q >= div_q};
      end else if (state_q == StRound) begin
        z_q      <= special_q ? spec_z_q : round_z;
        status_q <= special_q ? spec_st_q : round_st;
      end
`ifdef R5FP_DIV_EARLY_OUT_EN
      if (accept && spec_hit) begin
        z_q      <= spec_z;
        status_q <= spec_st;
      end
`endif
    end
  end

endmodule
